// File: rtl/bot_info_latch_if.sv
// Rojobot/processor handshake bundle for the bot info latch.
// The latch takes the slave side; the stimulus/processor side is master.
interface bot_info_latch_if #(
  parameter int OVR_W = 8
);
  logic             upd_sysregs;
  logic [31:0]      bot_info_in;
  logic             int_ack;
  logic [31:0]      bot_info_out;
  logic             bot_update_sync;
  logic [OVR_W-1:0] overrun_cnt;
  logic [15:0]      update_cnt;
  logic             bot_stale;

  modport master (
    output upd_sysregs, bot_info_in, int_ack,
    input  bot_info_out, bot_update_sync,
    input  overrun_cnt, update_cnt, bot_stale
  );

  modport slave (
    input  upd_sysregs, bot_info_in, int_ack,
    output bot_info_out, bot_update_sync,
    output overrun_cnt, update_cnt, bot_stale
  );
endinterface

// File: rtl/bot_info_latch.sv
// Latches rojobot status on update edges and holds an update-pending
// flag until the processor acknowledges; tracks overruns and staleness.
module bot_info_latch #(
  parameter int STALE_CYCLES = 5000000,
  parameter int OVR_W        = 8
) (
  input logic             clk,
  input logic             reset,
  bot_info_latch_if.slave bus
);
  localparam int SW = (STALE_CYCLES < 1) ? 1 : $clog2(STALE_CYCLES + 1);
  localparam logic [SW-1:0]    STALE_MAX = SW'(STALE_CYCLES);
  localparam logic [OVR_W-1:0] OVR_MAX   = '1;

  typedef enum logic {
    IDLE,
    PENDING
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             upd_q;
  logic             ack_q;
  logic             upd_ev;
  logic             ack_ev;
  logic             ovr_inc;
  logic             sync_q;
  logic [31:0]      info_q;
  logic [OVR_W-1:0] ovr_q;
  logic [15:0]      ucnt_q;
  logic [SW-1:0]    stale_q;

  assign upd_ev = bus.upd_sysregs & ~upd_q;
  assign ack_ev = bus.int_ack & ~ack_q;

  // An update always wins over a same-cycle ack.
  always_comb begin
    state_d = state_q;
    ovr_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (upd_ev) state_d = PENDING;
      end
      PENDING: begin
        if (upd_ev) ovr_inc = ~ack_ev;
        else if (ack_ev) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      upd_q   <= 1'b0;
      ack_q   <= 1'b0;
      sync_q  <= 1'b0;
      info_q  <= '0;
      ovr_q   <= '0;
      ucnt_q  <= '0;
      stale_q <= '0;
    end else begin
      state_q <= state_d;
      upd_q   <= bus.upd_sysregs;
      ack_q   <= bus.int_ack;
      sync_q  <= (state_d == PENDING);
      if (upd_ev) begin
        info_q <= bus.bot_info_in;
        ucnt_q <= ucnt_q + 16'd1;
      end
      if (ovr_inc && ovr_q != OVR_MAX)
        ovr_q <= ovr_q + OVR_W'(1);
      if (upd_ev)
        stale_q <= '0;
      else if (stale_q != STALE_MAX)
        stale_q <= stale_q + SW'(1);
    end
  end

  assign bus.bot_info_out    = info_q;
  assign bus.bot_update_sync = sync_q;
  assign bus.overrun_cnt     = ovr_q;
  assign bus.update_cnt      = ucnt_q;
  assign bus.bot_stale       = (stale_q == STALE_MAX);
endmodule

// File: tb/tb_bot_info_latch.sv
// Self-checking bench for bot_info_latch: vector table, corner
// sequences and random traffic against a behavioural model.
module tb_bot_info_latch;
  localparam int STALE = 16;
  localparam int OVR_W = 8;
  localparam int OMAX  = (1 << OVR_W) - 1;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bot_info_latch_if #(.OVR_W(OVR_W)) bus ();

  bot_info_latch #(
    .STALE_CYCLES(STALE),
    .OVR_W(OVR_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // behavioural model
  bit          m_pu;
  bit          m_pa;
  bit          m_pend;
  logic [31:0] m_out;
  int          m_ovr;
  int          m_uc;
  int          m_stale;

  typedef struct {
    logic        upd;
    logic        ack;
    logic [31:0] din;
    logic [31:0] exp_out;
    logic        exp_sync;
    int          exp_ovr;
    int          exp_uc;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mdl_reset();
    m_pu = 0; m_pa = 0; m_pend = 0;
    m_out = '0; m_ovr = 0; m_uc = 0; m_stale = 0;
  endtask

  task automatic mdl_step(input logic u, input logic a,
                          input logic [31:0] d);
    bit ue;
    bit ae;
    ue = u && !m_pu;
    ae = a && !m_pa;
    if (ue) begin
      if (m_pend && !ae && m_ovr < OMAX) m_ovr++;
      m_out   = d;
      m_uc    = (m_uc + 1) % 65536;
      m_stale = 0;
      m_pend  = 1;
    end else begin
      if (m_stale < STALE) m_stale++;
      if (ae) m_pend = 0;
    end
    m_pu = u;
    m_pa = a;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_out"}, 64'(bus.bot_info_out), 64'(m_out));
    chk({tag, "_sync"}, 64'(bus.bot_update_sync), 64'(m_pend));
    chk({tag, "_ovr"}, 64'(bus.overrun_cnt), 64'(m_ovr));
    chk({tag, "_ucnt"}, 64'(bus.update_cnt), 64'(m_uc));
    chk({tag, "_stale"}, 64'(bus.bot_stale), 64'(m_stale == STALE));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out"}, 64'(bus.bot_info_out), 64'd0);
    chk({tag, "_sync"}, 64'(bus.bot_update_sync), 64'd0);
    chk({tag, "_ovr"}, 64'(bus.overrun_cnt), 64'd0);
    chk({tag, "_ucnt"}, 64'(bus.update_cnt), 64'd0);
    chk({tag, "_stale"}, 64'(bus.bot_stale), 64'd0);
  endtask

  task automatic cyc(input logic u, input logic a, input logic [31:0] d,
                     input string tag);
    bus.upd_sysregs = u;
    bus.int_ack     = a;
    bus.bot_info_in = d;
    @(posedge clk);
    mdl_step(u, a, d);
    #1;
    chk_model(tag);
  endtask

  task automatic do_reset(input logic u, input logic a);
    bus.upd_sysregs = u;
    bus.int_ack     = a;
    bus.bot_info_in = '0;
    reset = 1'b1;
    mdl_reset();
    #1;
    chk_zero("rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1, 0, 32'h12345678, 32'h12345678, 1, 0, 1};
    vecs[1]  = '{0, 1, 32'h0,        32'h12345678, 0, 0, 1};
    vecs[2]  = '{0, 1, 32'h0,        32'h12345678, 0, 0, 1};
    vecs[3]  = '{1, 1, 32'hAAAA0001, 32'hAAAA0001, 1, 0, 2};
    vecs[4]  = '{0, 1, 32'h0,        32'hAAAA0001, 1, 0, 2};
    vecs[5]  = '{0, 0, 32'h0,        32'hAAAA0001, 1, 0, 2};
    vecs[6]  = '{1, 0, 32'hA,        32'hA,        1, 1, 3};
    vecs[7]  = '{0, 0, 32'h0,        32'hA,        1, 1, 3};
    vecs[8]  = '{1, 0, 32'hB,        32'hB,        1, 2, 4};
    vecs[9]  = '{1, 0, 32'hC,        32'hB,        1, 2, 4};
    vecs[10] = '{0, 0, 32'h0,        32'hB,        1, 2, 4};
    vecs[11] = '{1, 1, 32'hD,        32'hD,        1, 2, 5};
    vecs[12] = '{0, 0, 32'h0,        32'hD,        1, 2, 5};
    vecs[13] = '{0, 1, 32'h0,        32'hD,        0, 2, 5};

    reset = 1'b1;
    bus.upd_sysregs = 1'b0;
    bus.int_ack     = 1'b0;
    bus.bot_info_in = '0;
    #2;
    do_reset(0, 0);

    // vector table
    for (int i = 0; i < 14; i++) begin
      cyc(vecs[i].upd, vecs[i].ack, vecs[i].din, "vec");
      chk($sformatf("vec%0d_out", i), 64'(bus.bot_info_out),
          64'(vecs[i].exp_out));
      chk($sformatf("vec%0d_sync", i), 64'(bus.bot_update_sync),
          64'(vecs[i].exp_sync));
      chk($sformatf("vec%0d_ovr", i), 64'(bus.overrun_cnt),
          64'(vecs[i].exp_ovr));
      chk($sformatf("vec%0d_ucnt", i), 64'(bus.update_cnt),
          64'(vecs[i].exp_uc));
    end

    // three updates without ack
    do_reset(0, 0);
    cyc(1, 0, 32'hA, "ovr3"); cyc(0, 0, 0, "ovr3");
    cyc(1, 0, 32'hB, "ovr3"); cyc(0, 0, 0, "ovr3");
    cyc(1, 0, 32'hC, "ovr3");
    chk("ovr3_out", 64'(bus.bot_info_out), 64'hC);
    chk("ovr3_ovr", 64'(bus.overrun_cnt), 64'd2);
    chk("ovr3_ucnt", 64'(bus.update_cnt), 64'd3);
    chk("ovr3_sync", 64'(bus.bot_update_sync), 64'd1);

    // held ack fires once
    do_reset(0, 0);
    cyc(1, 0, 32'h1111, "hack");
    cyc(0, 1, 0, "hack");
    chk("hack_clear", 64'(bus.bot_update_sync), 64'd0);
    for (int i = 0; i < 9; i++) cyc(0, 1, 0, "hack");
    cyc(1, 1, 32'h2222, "hack");
    chk("hack_repend", 64'(bus.bot_update_sync), 64'd1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, "hack");
    chk("hack_hold", 64'(bus.bot_update_sync), 64'd1);

    // stale timing
    do_reset(0, 0);
    for (int i = 0; i < STALE - 1; i++) cyc(0, 0, 0, "stl");
    chk("stale_15", 64'(bus.bot_stale), 64'd0);
    cyc(0, 0, 0, "stl");
    chk("stale_16", 64'(bus.bot_stale), 64'd1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, "stl");
    chk("stale_sat", 64'(bus.bot_stale), 64'd1);
    cyc(1, 0, 32'h77, "stl");
    chk("stale_clr", 64'(bus.bot_stale), 64'd0);

    // overrun saturation
    do_reset(0, 0);
    cyc(1, 0, 32'h0, "sat"); cyc(0, 0, 0, "sat");
    for (int i = 0; i < 300; i++) begin
      cyc(1, 0, 32'(i), "sat");
      cyc(0, 0, 0, "sat");
    end
    chk("sat_ovr", 64'(bus.overrun_cnt), 64'd255);
    chk("sat_ucnt", 64'(bus.update_cnt), 64'd301);

    // strobe high at reset release counts as an event
    do_reset(1, 0);
    cyc(1, 0, 32'hBEEF, "rel");
    chk("rel_sync", 64'(bus.bot_update_sync), 64'd1);
    chk("rel_ucnt", 64'(bus.update_cnt), 64'd1);

    // async reset mid-PENDING
    cyc(0, 0, 0, "async");
    #3;
    reset = 1'b1;
    #1;
    chk_zero("async");
    mdl_reset();
    bus.upd_sysregs = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // random traffic, dense then sparse
    for (int i = 0; i < 1500; i++)
      cyc(1'($urandom % 2), 1'(($urandom % 3) == 0), $urandom, "rnd");
    for (int i = 0; i < 1500; i++)
      cyc(1'(($urandom % 40) == 0), 1'(($urandom % 5) == 0), $urandom,
          "rnds");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bot_info_latch.md
BOT_INFO_LATCH -- requirements
Module: bot_info_latch

Interface
REQ-001 Parameter STALE_CYCLES, default 5000000, clock cycles without an update event before bot_stale asserts (0.1 s at 50 MHz).
REQ-002 Parameter OVR_W, default 8, width of the overrun counter.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 upd_sysregs  input  1  rojobot register-update strobe, synchronous to clk, level or pulse.
REQ-006 bot_info_in  input  32  {LocX, LocY, Sensors, BotInfo} from rojobot, valid while upd_sysregs high.
REQ-007 int_ack  input  1  processor acknowledge, synchronous to clk, level.
REQ-008 bot_info_out  output  32  registered snapshot presented to processor as H_BOT_INFO.
REQ-009 bot_update_sync  output  1  update-pending flag presented to processor as H_BOT_UPDATE_SYNC.
REQ-010 overrun_cnt  output  OVR_W  count of updates replacing an unacknowledged snapshot.
REQ-011 update_cnt  output  16  count of update events accepted.
REQ-012 bot_stale  output  1  high when no update event for STALE_CYCLES cycles.

Function
REQ-013 Update event SHALL be upd_sysregs==1 in a cycle where its registered previous value is 0; a held-high strobe yields one event.
REQ-014 Ack event SHALL be int_ack==1 in a cycle where its registered previous value is 0; held-high ack yields one event.
REQ-015 On an update event bot_info_out SHALL load bot_info_in at that clock edge; visible 1 cycle after upd_sysregs first sampled high.
REQ-016 bot_info_out SHALL be unchanged in all cycles without an update event.
REQ-017 FSM states: IDLE (bot_update_sync=0), PENDING (bot_update_sync=1); bot_update_sync is a registered decode of state.
REQ-018 IDLE -> PENDING on update event; ack event in IDLE ignored.
REQ-019 PENDING -> IDLE on ack event without simultaneous update event.
REQ-020 PENDING with simultaneous update and ack event SHALL stay PENDING with new snapshot; overrun_cnt unchanged.
REQ-021 PENDING with update event and no ack event SHALL stay PENDING, load new snapshot (latest wins), increment overrun_cnt.
REQ-022 overrun_cnt SHALL saturate at 2^OVR_W-1.
REQ-023 update_cnt SHALL increment by 1 per update event and wrap 0xFFFF -> 0x0000.
REQ-024 Stale counter SHALL clear to 0 on each update event, else increment, saturating at STALE_CYCLES.
REQ-025 bot_stale SHALL be 1 when stale counter equals STALE_CYCLES, 0 otherwise; clears the cycle after an update event.
REQ-026 Stale counter width SHALL be ceil(log2(STALE_CYCLES+1)) bits.

Reset
REQ-027 While reset=1: state IDLE, bot_info_out=0, bot_update_sync=0, overrun_cnt=0, update_cnt=0, stale counter=0, bot_stale=0, edge-detect registers=0.
REQ-028 Reset asserted mid-PENDING SHALL clear all state immediately, without a clock edge.
REQ-029 If upd_sysregs or int_ack is high at reset release, that SHALL count as an event on the first clock edge after release.

Verification
REQ-030 Reset release, one-cycle upd_sysregs with bot_info_in=0x12345678 -> next cycle bot_info_out=0x12345678, bot_update_sync=1, update_cnt=1.
REQ-031 From PENDING, one-cycle int_ack -> bot_update_sync=0 next cycle; int_ack held 10 cycles then new update -> PENDING, not cleared again.
REQ-032 Three updates (0xA, 0xB, 0xC) without ack -> bot_info_out=0xC, overrun_cnt=2, update_cnt=3, bot_update_sync=1.
REQ-033 Update and ack events in same cycle while PENDING -> stays PENDING, new snapshot, overrun_cnt unchanged.
REQ-034 STALE_CYCLES=16, no updates -> bot_stale=1 after 16 cycles; one update -> bot_stale=0 next cycle; 300 overruns with OVR_W=8 -> overrun_cnt=255.
REQ-035 Reset pulse asserted between clock edges while PENDING -> all outputs 0 before next edge.
